// File: rtl/uart_rx_cfg_if.sv
// Receive-side word interface: the receiver (master) presents a received word plus error
// flags, and the consumer (slave) accepts it.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    // rx_valid rises with a new word and stays high, with rx_data/frame_err/parity_err
    // frozen, until a clock edge where rx_ready is also high. rx_ready is ignored while
    // rx_valid is low. overrun is a separate 1-cycle pulse that is not tied to rx_valid.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling with a 3-sample majority vote, selectable
// data/parity/stop format, and a one-word valid/ready holding register.
module uart_rx_cfg #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_cfg_if.master    bus,
    output logic [2:0]       state_dbg
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           sub_cnt_q, sub_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 commit_q, commit_d;
    logic                 cmt_ferr_q, cmt_ferr_d;
    logic                 cmt_perr_q, cmt_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    logic rx_s;
    logic tick;
    logic at_mid;
    logic maj;
    logic ones;
    logic perr_w;
    logic stop_ferr;

    assign rx_s   = sync2_q;
    assign tick   = (tick_cnt_q == TW'(TICK_DIV - 1));
    // Ticks 7 and 8 are latched; the vote happens on tick 9 using the live sample.
    assign at_mid = tick && (sub_cnt_q == 4'd9);
    assign maj    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    assign ones      = ^{shift_q, par_bit_q};
    assign perr_w    = (PARITY == 1) ? ~ones : ((PARITY == 2) ? ones : 1'b0);
    assign stop_ferr = ferr_acc_q | ~maj;

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx;
        sync2_d      = sync1_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
        sub_cnt_d    = tick ? sub_cnt_q + 4'd1 : sub_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        s0_d         = (tick && sub_cnt_q == 4'd7) ? rx_s : s0_q;
        s1_d         = (tick && sub_cnt_q == 4'd8) ? rx_s : s1_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        ferr_acc_d   = ferr_acc_q;
        commit_d     = 1'b0;
        cmt_ferr_d   = cmt_ferr_q;
        cmt_perr_d   = cmt_perr_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    sub_cnt_d  = 4'd0;
                end
            end
            S_START: begin
                if (at_mid) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_cnt_d  = 4'd0;
                        ferr_acc_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (at_mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_mid) begin
                    par_bit_d = maj;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (at_mid) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        // Leave mid-stop-bit so a start bit with no idle gap is still caught.
                        commit_d   = 1'b1;
                        cmt_ferr_d = stop_ferr;
                        cmt_perr_d = perr_w;
                        state_d    = maj ? S_IDLE : S_BRKWAIT;
                    end else begin
                        ferr_acc_d = stop_ferr;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_BRKWAIT: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (commit_q) begin
            // A full holding register wins: the new word is dropped, not the held one.
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d    = shift_q;
                frame_err_d  = cmt_ferr_q;
                parity_err_d = cmt_perr_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tick_cnt_q   <= '0;
            sub_cnt_q    <= 4'd0;
            bit_cnt_q    <= 4'd0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            commit_q     <= 1'b0;
            cmt_ferr_q   <= 1'b0;
            cmt_perr_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            tick_cnt_q   <= tick_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            ferr_acc_q   <= ferr_acc_d;
            commit_q     <= commit_d;
            cmt_ferr_q   <= cmt_ferr_d;
            cmt_perr_q   <= cmt_perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, both at 4 clocks
// per oversample tick so each bit lasts 64 clocks.
module tb_uart_rx_cfg;

    localparam int BIT = 64;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rx_a = 1'b1;
    logic rx_p = 1'b1;
    logic [2:0] st_a;
    logic [2:0] st_p;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_a   = 0;
    int ovr_p   = 0;

    // Entries are {parity_err, frame_err, rx_data}.
    logic [9:0] got_a_q[$];
    logic [9:0] got_p_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_p ();

    uart_rx_cfg #(
        .CLK_HZ(100000000), .BAUD(1562500), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .bus(if_a.master), .state_dbg(st_a)
    );

    uart_rx_cfg #(
        .CLK_HZ(100000000), .BAUD(1562500), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .bus(if_p.master), .state_dbg(st_p)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.rx_valid && if_a.rx_ready)
                got_a_q.push_back({if_a.parity_err, if_a.frame_err, if_a.rx_data});
            if (if_p.rx_valid && if_p.rx_ready)
                got_p_q.push_back({if_p.parity_err, if_p.frame_err, if_p.rx_data});
            if (if_a.overrun) ovr_a++;
            if (if_p.overrun) ovr_p++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_p = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_val);
        set_line(sel, 1'b0);
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, data[i]);
            wait_clks(BIT);
        end
        if (has_par) begin
            set_line(sel, par_bit);
            wait_clks(BIT);
        end
        set_line(sel, stop_val);
        wait_clks(BIT);
        set_line(sel, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(4);
        n_tests++;
        if ({if_a.rx_valid, if_a.rx_data, if_a.frame_err, if_a.parity_err, if_a.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got %h expected 000",
                     {if_a.rx_valid, if_a.rx_data, if_a.frame_err, if_a.parity_err, if_a.overrun});
        end
        n_tests++;
        if (if_p.rx_valid !== 1'b0 || if_p.rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs_p: got valid=%b data=%h expected 0/00", if_p.rx_valid, if_p.rx_data);
        end
        n_tests++;
        if (st_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", st_a);
        end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_basic();
        int b;
        b = got_a_q.size();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", got_a_q.size() - b, 1);
        end else begin
            n_tests++;
            if (got_a_q[b] !== 10'h0A5) begin
                n_fail++;
                $display("FAIL basic_word: got %h expected 0a5", got_a_q[b]);
            end
        end
        n_tests++;
        if (if_a.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_drop: got %b expected 0", if_a.rx_valid);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] pats[5];
        int b;
        pats[0] = 8'hFF; pats[1] = 8'h01; pats[2] = 8'h80; pats[3] = 8'h00; pats[4] = 8'h6B;
        b = got_a_q.size();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_frame(0, pats[i], 1'b0, 1'b0, 1'b1);
            exp_q.push_back({2'b00, pats[i]});
            wait_clks(BIT);
        end
        wait_clks(BIT);
        n_tests++;
        if (got_a_q.size() !== b + exp_q.size()) begin
            n_fail++;
            $display("FAIL patterns_count: got %0d expected %0d", got_a_q.size() - b, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_tests++;
                if (got_a_q[b + k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL patterns_word%0d: got %h expected %h", k, got_a_q[b + k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_frame_err();
        int b;
        b = got_a_q.size();
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 1) begin
            n_fail++;
            $display("FAIL frame_err_count: got %0d expected 1", got_a_q.size() - b);
        end else begin
            n_tests++;
            if (got_a_q[b] !== 10'h133) begin
                n_fail++;
                $display("FAIL frame_err_word: got %h expected 133", got_a_q[b]);
            end
        end
        n_tests++;
        if (st_a !== 3'd0) begin
            n_fail++;
            $display("FAIL frame_err_idle: got %0d expected 0", st_a);
        end
    endtask

    task automatic test_parity();
        int b;
        b = got_p_q.size();
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        wait_clks(BIT);
        send_frame(1, 8'h3D, 1'b1, 1'b1, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_p_q.size() !== b + 2) begin
            n_fail++;
            $display("FAIL parity_count: got %0d expected 2", got_p_q.size() - b);
        end else begin
            n_tests++;
            if (got_p_q[b] !== 10'h23C) begin
                n_fail++;
                $display("FAIL parity_bad_word: got %h expected 23c", got_p_q[b]);
            end
            n_tests++;
            if (got_p_q[b + 1] !== 10'h03D) begin
                n_fail++;
                $display("FAIL parity_good_word: got %h expected 03d", got_p_q[b + 1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b;
        b = got_a_q.size();
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h56, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 3", got_a_q.size() - b);
        end else begin
            n_tests++;
            if ({got_a_q[b], got_a_q[b + 1], got_a_q[b + 2]} !== {10'h012, 10'h034, 10'h056}) begin
                n_fail++;
                $display("FAIL b2b_words: got %h %h %h expected 012 034 056",
                         got_a_q[b], got_a_q[b + 1], got_a_q[b + 2]);
            end
        end
    endtask

    task automatic test_overrun();
        int b;
        int ob;
        b  = got_a_q.size();
        ob = ovr_a;
        if_a.rx_ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (if_a.rx_valid !== 1'b1 || if_a.rx_data !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b data=%h expected 1/11", if_a.rx_valid, if_a.rx_data);
        end
        n_tests++;
        if (ovr_a - ob !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d expected 1", ovr_a - ob);
        end
        if_a.rx_ready = 1'b1;
        wait_clks(3);
        n_tests++;
        if (if_a.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_release: got %b expected 0", if_a.rx_valid);
        end
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 1) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d expected 1", got_a_q.size() - b);
        end else begin
            n_tests++;
            if (got_a_q[b] !== 10'h011) begin
                n_fail++;
                $display("FAIL overrun_word: got %h expected 011", got_a_q[b]);
            end
        end
    endtask

    task automatic test_glitch();
        int b;
        int ob;
        b  = got_a_q.size();
        ob = ovr_a;
        rx_a = 1'b0;
        wait_clks(3);
        rx_a = 1'b1;
        wait_clks(16);
        n_tests++;
        if (st_a !== 3'd1) begin
            n_fail++;
            $display("FAIL glitch_start_seen: got %0d expected 1", st_a);
        end
        wait_clks(BIT * 2);
        n_tests++;
        if (st_a !== 3'd0 || if_a.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: got state=%0d valid=%b expected 0/0", st_a, if_a.rx_valid);
        end
        n_tests++;
        if (got_a_q.size() !== b || ovr_a !== ob) begin
            n_fail++;
            $display("FAIL glitch_no_word: got %0d words %0d overruns expected 0/0",
                     got_a_q.size() - b, ovr_a - ob);
        end
    endtask

    task automatic test_break();
        int b;
        b = got_a_q.size();
        rx_a = 1'b0;
        wait_clks(BIT * 30);
        n_tests++;
        if (got_a_q.size() !== b + 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d expected 1", got_a_q.size() - b);
        end else begin
            n_tests++;
            if (got_a_q[b] !== 10'h100) begin
                n_fail++;
                $display("FAIL break_word: got %h expected 100", got_a_q[b]);
            end
        end
        n_tests++;
        if (st_a !== 3'd5) begin
            n_fail++;
            $display("FAIL break_wait_state: got %0d expected 5", st_a);
        end
        rx_a = 1'b1;
        wait_clks(BIT);
        n_tests++;
        if (st_a !== 3'd0) begin
            n_fail++;
            $display("FAIL break_release: got %0d expected 0", st_a);
        end
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 2) begin
            n_fail++;
            $display("FAIL break_next_count: got %0d expected 2", got_a_q.size() - b);
        end else begin
            n_tests++;
            if (got_a_q[b + 1] !== 10'h05A) begin
                n_fail++;
                $display("FAIL break_next_word: got %h expected 05a", got_a_q[b + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        b = got_a_q.size();
        rx_a = 1'b0;
        wait_clks(BIT);
        rx_a = 1'b1;
        wait_clks(BIT * 3);
        n_tests++;
        if (st_a !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_mid_in_data: got %0d expected 2", st_a);
        end
        rst = 1'b1;
        wait_clks(3);
        n_tests++;
        if ({st_a, if_a.rx_valid, if_a.rx_data, if_a.frame_err, if_a.parity_err, if_a.overrun} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0000",
                     {st_a, if_a.rx_valid, if_a.rx_data, if_a.frame_err, if_a.parity_err, if_a.overrun});
        end
        rst = 1'b0;
        wait_clks(BIT * 8);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT * 2);
        n_tests++;
        if (got_a_q.size() !== b + 1) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d expected 1", got_a_q.size() - b);
        end else begin
            n_tests++;
            if (got_a_q[b] !== 10'h081) begin
                n_fail++;
                $display("FAIL reset_mid_word: got %h expected 081", got_a_q[b]);
            end
        end
    endtask

    initial begin
        if_a.rx_ready = 1'b1;
        if_p.rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_patterns();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
